// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter, MSB first, write-only; bytes arrive on a valid/ready handshake.
// Latency: CS falls and MOSI=b7 one cycle after accept; done pulses 16*CLK_DIV cycles after that.
// Backpressure: tx_ready is low while a byte is shifting, in the CS hold and in the inter-frame gap.
module spi_master_tx #(
  parameter int CLK_DIV = 4,
  parameter int CS_IDLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       sck,
  output logic       cs,
  output logic       mosi,
  output logic       busy,
  output logic       done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_NEXT,
    HOLD,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    sr_q, sr_d;      // bits still to be driven, next one in bit 7
  logic          last_q, last_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          sck_q, sck_d;
  logic          cs_q, cs_d;
  logic          mosi_q, mosi_d;
  logic          rdy_q, rdy_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept;
  logic          div_end;

  assign accept  = tx_valid & rdy_q;
  assign div_end = (div_q == DIV_MAX);

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    last_d  = last_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE, WAIT_NEXT: begin
        // A new byte starts identically whether or not CS is already low.
        if (accept) begin
          state_d = SHIFT;
          sr_d    = {tx_data[6:0], 1'b0};
          last_d  = tx_last;
          div_d   = '0;
          bit_d   = '0;
          cs_d    = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = tx_data[7];
        end
      end
      SHIFT: begin
        div_d = div_end ? '0 : div_q + DW'(1);
        if (div_end) begin
          sck_d = ~sck_q;
          if (sck_q) begin
            // Falling edge: either the byte is complete or the next bit goes out.
            if (bit_q == 3'd7) begin
              done_d  = 1'b1;
              state_d = last_q ? HOLD : WAIT_NEXT;
            end else begin
              bit_d  = bit_q + 3'd1;
              mosi_d = sr_q[7];
              sr_d   = {sr_q[6:0], 1'b0};
            end
          end
        end
      end
      HOLD: begin
        // Keep CS low for one SCK half-period after the last falling edge.
        div_d = div_end ? '0 : div_q + DW'(1);
        if (div_end) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == GAP_MAX) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready is withheld on the byte-end cycle itself so done and accept never coincide.
    rdy_d  = ((state_d == IDLE) || (state_d == WAIT_NEXT)) && !done_d;
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      last_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sck_q   <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      last_q  <= last_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx_ready = rdy_q;
  assign sck      = sck_q;
  assign cs       = cs_q;
  assign mosi     = mosi_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: two instances (CLK_DIV=4 and CLK_DIV=2, CS_IDLE=2 both).
// A timeline model predicts every output on every cycle from the accept time and byte.
// Directed scenarios add literal timing/bit expectations captured by an edge monitor.
module tb_spi_master_tx;

  localparam int M_RESET = 0;
  localparam int M_IDLE  = 1;
  localparam int M_FRAME = 2;
  localparam int CSI     = 2;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data  [2];
  logic       tx_valid [2];
  logic       tx_last  [2];
  logic       rdy_w [2];
  logic       sck_w [2];
  logic       cs_w  [2];
  logic       mosi_w[2];
  logic       busy_w[2];
  logic       done_w[2];

  int nvec;
  int nfail;
  int now;

  // model state
  int         mode   [2];
  int         t0     [2];
  logic [7:0] mbyte  [2];
  logic       lst    [2];
  int         acc_cnt[2];
  logic e_sck[2], e_cs[2], e_mosi[2], e_rdy[2], e_busy[2], e_done[2];

  // edge monitor
  int   pr_i;
  bit   pr_on;
  int   pr_base;
  int   nr, nd, cs_up_t, rdy_up_t, bad_mosi;
  int   rise_t[32];
  logic rise_b[32];
  int   done_t[4];
  logic p_sck, p_cs, p_mosi, p_rdy;

  spi_master_tx #(.CLK_DIV(4), .CS_IDLE(CSI)) u_dut0 (
    .clk(clk), .reset(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_last(tx_last[0]),
    .tx_ready(rdy_w[0]), .sck(sck_w[0]), .cs(cs_w[0]), .mosi(mosi_w[0]), .busy(busy_w[0]),
    .done(done_w[0])
  );

  spi_master_tx #(.CLK_DIV(2), .CS_IDLE(CSI)) u_dut1 (
    .clk(clk), .reset(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_last(tx_last[1]),
    .tx_ready(rdy_w[1]), .sck(sck_w[1]), .cs(cs_w[1]), .mosi(mosi_w[1]), .busy(busy_w[1]),
    .done(done_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dv(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  // Expected outputs for cycle 'now', from the frame timeline relative to the accept cycle.
  task automatic model_eval(input int i);
    int rel, d, half;
    d = dv(i);
    e_sck[i] = 1'b0; e_cs[i] = 1'b1; e_mosi[i] = 1'b0;
    e_rdy[i] = 1'b0; e_busy[i] = 1'b0; e_done[i] = 1'b0;
    if (mode[i] == M_IDLE) begin
      e_rdy[i] = 1'b1;
    end else if (mode[i] == M_FRAME) begin
      rel = now - t0[i] - 1;
      if (rel < 16 * d) begin
        half = rel / d;
        e_cs[i] = 1'b0; e_busy[i] = 1'b1;
        e_sck[i]  = ((half % 2) == 1);
        e_mosi[i] = mbyte[i][7 - half / 2];
      end else if (rel == 16 * d) begin
        e_cs[i] = 1'b0; e_busy[i] = 1'b1; e_done[i] = 1'b1; e_mosi[i] = mbyte[i][0];
      end else if (!lst[i]) begin
        e_cs[i] = 1'b0; e_busy[i] = 1'b1; e_rdy[i] = 1'b1; e_mosi[i] = mbyte[i][0];
      end else if (rel < 17 * d) begin
        e_cs[i] = 1'b0; e_busy[i] = 1'b1; e_mosi[i] = mbyte[i][0];
      end else if (rel < 17 * d + CSI) begin
        e_busy[i] = 1'b1;
      end else begin
        e_rdy[i] = 1'b1;
      end
    end
  endtask

  // Model: advances on every rising clock edge using the same inputs the DUTs sample.
  initial begin
    now = 0;
    for (int i = 0; i < 2; i++) begin
      mode[i] = M_RESET; acc_cnt[i] = 0; t0[i] = 0; mbyte[i] = '0; lst[i] = 1'b0;
      e_rdy[i] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          mode[i] = M_RESET;
        end else if (mode[i] == M_RESET) begin
          mode[i] = M_IDLE;
        end else if (tx_valid[i] && e_rdy[i]) begin
          mode[i]  = M_FRAME;
          t0[i]    = now;
          mbyte[i] = tx_data[i];
          lst[i]   = tx_last[i];
          acc_cnt[i]++;
        end
      end
      now++;
      for (int i = 0; i < 2; i++) model_eval(i);
    end
  end

  // Compare: every cycle, both instances, all six outputs.
  initial forever begin
    logic [5:0] act, req;
    @(negedge clk);
    if (now > 0) begin
      for (int i = 0; i < 2; i++) begin
        act = {sck_w[i], cs_w[i], mosi_w[i], rdy_w[i], busy_w[i], done_w[i]};
        req = {e_sck[i], e_cs[i], e_mosi[i], e_rdy[i], e_busy[i], e_done[i]};
        nvec++;
        if (act !== req) begin
          nfail++;
          $display("FAIL cycle_compare inst%0d cycle %0d: sck/cs/mosi/rdy/busy/done got %b required %b",
                   i, now, act, req);
        end
      end
    end
  end

  // Edge monitor: records SCK rising edges, done pulses, CS/ready returns relative to accept.
  initial forever begin
    @(negedge clk);
    if (pr_on) begin
      if (sck_w[pr_i] && !p_sck && nr < 32) begin
        rise_t[nr] = now - pr_base; rise_b[nr] = mosi_w[pr_i]; nr++;
      end
      if (done_w[pr_i] && nd < 4) begin done_t[nd] = now - pr_base; nd++; end
      if (cs_w[pr_i] && !p_cs && cs_up_t < 0) cs_up_t = now - pr_base;
      if (rdy_w[pr_i] && !p_rdy && rdy_up_t < 0) rdy_up_t = now - pr_base;
      if (!cs_w[pr_i] && !p_cs && (mosi_w[pr_i] !== p_mosi) && !(p_sck && !sck_w[pr_i]))
        bad_mosi++;
      p_sck = sck_w[pr_i]; p_cs = cs_w[pr_i]; p_mosi = mosi_w[pr_i]; p_rdy = rdy_w[pr_i];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int req);
    nvec++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic l);
    int a0, n;
    a0 = acc_cnt[i];
    tx_valid[i] = 1'b1; tx_data[i] = d; tx_last[i] = l;
    n = 0;
    while (acc_cnt[i] == a0 && n < 200) begin @(posedge clk); #1; n++; end
    if (acc_cnt[i] == a0) begin
      nvec++; nfail++;
      $display("FAIL accept_timeout inst%0d: byte %h not accepted in 200 cycles, required acceptance", i, d);
    end
    tx_valid[i] = 1'b0;
  endtask

  task automatic probe_start(input int i);
    pr_i = i; pr_base = t0[i];
    nr = 0; nd = 0; cs_up_t = -1; rdy_up_t = -1; bad_mosi = 0;
    for (int k = 0; k < 4; k++) done_t[k] = -1;
    p_sck = 1'b0; p_cs = 1'b1; p_mosi = 1'b0; p_rdy = 1'b0;
    pr_on = 1'b1;
  endtask

  // Literal checks of one single-byte frame against hand-computed cycle offsets.
  task automatic check_single(input string nm, input logic [7:0] b, input int first_rise,
                              input int period, input int done_at, input int cs_at, input int rdy_at);
    logic [7:0] got;
    got = '0;
    chk({nm, "_rises"}, nr, 8);
    for (int k = 0; k < 8 && k < nr; k++) begin
      got[7 - k] = rise_b[k];
      chk($sformatf("%s_rise%0d_time", nm, k), rise_t[k], first_rise + period * k);
    end
    chk({nm, "_bits"}, int'(got), int'(b));
    chk({nm, "_done_count"}, nd, 1);
    chk({nm, "_done_time"}, done_t[0], done_at);
    chk({nm, "_cs_rise"}, cs_up_t, cs_at);
    chk({nm, "_ready_back"}, rdy_up_t, rdy_at);
  endtask

  initial begin
    logic [15:0] got16;
    nvec = 0; nfail = 0; pr_on = 1'b0; pr_i = 0; pr_base = 0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin tx_valid[i] = 1'b0; tx_data[i] = '0; tx_last[i] = 1'b0; end

    // reset values, then ready after release
    wait_cycles(3);
    chk("reset_outputs", int'({sck_w[0], cs_w[0], mosi_w[0], rdy_w[0], busy_w[0], done_w[0]}), 16);
    rst = 1'b0;
    wait_cycles(1);
    chk("ready_after_reset_div4", int'(rdy_w[0]), 1);
    chk("ready_after_reset_div2", int'(rdy_w[1]), 1);
    wait_cycles(3);

    // single byte 0xA5, last=1
    send(0, 8'hA5, 1'b1);
    probe_start(0);
    wait_cycles(80);
    pr_on = 1'b0;
    check_single("a5", 8'hA5, 5, 8, 65, 69, 71);

    // burst 0x3C (not last) then 0xC3 (last), second presented at once
    send(0, 8'h3C, 1'b0);
    probe_start(0);
    send(0, 8'hC3, 1'b1);
    wait_cycles(80);
    pr_on = 1'b0;
    chk("burst_rises", nr, 16);
    got16 = '0;
    for (int k = 0; k < 16 && k < nr; k++) got16[15 - k] = rise_b[k];
    chk("burst_bits", int'(got16), 16'h3CC3);
    chk("burst_done_count", nd, 2);
    chk("burst_done0_time", done_t[0], 65);
    chk("burst_done1_time", done_t[1], 131);
    chk("burst_cs_first_rise", cs_up_t, 135);
    wait_cycles(5);

    // reset one cycle after rising edge 2 of 0xF0, then a clean 0xFF
    send(0, 8'hF0, 1'b1);
    while (now < t0[0] + 22) begin @(posedge clk); #1; end
    rst = 1'b1;
    wait_cycles(1);
    chk("abort_outputs", int'({sck_w[0], cs_w[0], mosi_w[0], busy_w[0], done_w[0]}), 8);
    rst = 1'b0;
    wait_cycles(3);
    send(0, 8'hFF, 1'b1);
    probe_start(0);
    wait_cycles(80);
    pr_on = 1'b0;
    check_single("after_abort_ff", 8'hFF, 5, 8, 65, 69, 71);

    // valid held with changing data while the byte is in flight
    send(0, 8'h96, 1'b1);
    probe_start(0);
    for (int k = 0; k < 60; k++) begin
      tx_valid[0] = 1'b1;
      tx_data[0]  = 8'($urandom_range(0, 255));
      tx_last[0]  = 1'($urandom_range(0, 1));
      wait_cycles(1);
    end
    tx_valid[0] = 1'b0;
    wait_cycles(25);
    pr_on = 1'b0;
    check_single("held_valid_96", 8'h96, 5, 8, 65, 69, 71);

    // CLK_DIV=2 instance
    send(1, 8'h00, 1'b1);
    probe_start(1);
    wait_cycles(45);
    pr_on = 1'b0;
    check_single("div2_00", 8'h00, 3, 4, 33, 35, 37);
    send(1, 8'hFF, 1'b1);
    probe_start(1);
    wait_cycles(45);
    pr_on = 1'b0;
    check_single("div2_ff", 8'hFF, 3, 4, 33, 35, 37);
    send(1, 8'h5A, 1'b1);
    probe_start(1);
    wait_cycles(45);
    pr_on = 1'b0;
    check_single("div2_5a", 8'h5A, 3, 4, 33, 35, 37);
    chk("div2_mosi_only_on_falling", bad_mosi, 0);

    wait_cycles(5);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
